// File: rtl/afifo_wr_arb.sv
// Round-robin packet arbiter sharing one async FIFO write port; tags each beat with the requester ID.
// Optional stall statistic counter is built only when AFIFO_ARB_STALL_CNT_EN is defined.
module afifo_wr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = 2
) (
  input  logic              wr_clk,
  input  logic              wr_reset_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_rdy,
  output logic              fifo_wr_en,
  output logic [IDW+W-1:0]  fifo_wr_data,
  input  logic              fifo_full,
  output logic              grant_vld,
  output logic [IDW-1:0]    grant_id,
  output logic [15:0]       stall_cnt
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                   state_q;
  logic [IDW-1:0]           rr_ptr_q;
  logic [IDW-1:0]           grant_id_q;
  logic [IDW-1:0]           winner;
  logic [IDW-1:0]           next_ptr;
  logic [IDW-1:0]           idx;
  logic                     found;
  logic                     busy;
  logic                     cur_vld;
  logic                     cur_last;
  logic                     accept;
  logic [NREQ-1:0][W-1:0]   data_arr;

  assign data_arr = req_data;
  assign busy     = (state_q == StBusy);
  assign cur_vld  = req_vld[grant_id_q];
  assign cur_last = req_last[grant_id_q];
  assign next_ptr = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  // First valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_rdy
    assign req_rdy[k] = busy & ~fifo_full & (grant_id_q == IDW'(k));
  end

  assign fifo_wr_en   = busy & cur_vld & ~fifo_full;
  assign accept       = fifo_wr_en;
  assign fifo_wr_data = {grant_id_q, data_arr[grant_id_q]};
  assign grant_vld    = busy;
  assign grant_id     = grant_id_q;

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found && !fifo_full) begin
            grant_id_q <= winner;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (accept && cur_last) begin
            state_q  <= StIdle;
            rr_ptr_q <= next_ptr;
          end
        end
      endcase
    end
  end

`ifdef AFIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      stall_cnt_q <= '0;
    end else if (busy && cur_vld && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
